// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one LAT-cycle floating-point multiplier among NREQ requesters.
// Results are tagged with their requester and queued in a credit-protected FIFO.
module fp_mul_sched #(
    parameter int NREQ  = 4,
    parameter int LAT   = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*32-1:0]       req_a,
    input  logic [NREQ*32-1:0]       req_b,
    output logic [31:0]              mul_a,
    output logic [31:0]              mul_b,
    input  logic [31:0]              mul_result,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [31:0]              rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1) + 1;

    logic              issue_valid;
    logic [IDW-1:0]    issue_tag;
    logic [LAT-1:0]    pipe_valid;
    logic [IDW-1:0]    pipe_tag [LAT];
    logic [IDW-1:0]    fifo_id [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     occupancy;
    logic [IDW-1:0]    last_grant;

    logic              push;
    logic              pop;
    logic              accept;
    logic [CW-1:0]     credit;
    logic              has_credit;
    logic              grant_any;
    logic [IDW-1:0]    grant_idx;
    logic [IDW-1:0]    cand;

    assign rsp_valid = (occupancy != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = pipe_valid[LAT-1];
    assign accept    = |req_ready;
    assign busy      = issue_valid | (|pipe_valid) | rsp_valid;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;

    // Every operation from issue to pop holds one credit, so the FIFO can never overflow.
    always_comb begin
        credit = CW'(issue_valid) + occupancy;
        for (int k = 0; k < LAT; k++) begin
            credit = credit + CW'(pipe_valid[k]);
        end
        has_credit = (credit - CW'(pop)) < CW'(DEPTH);

        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end

        req_ready = '0;
        if (grant_any && has_credit && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_tag   <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            pipe_valid  <= '0;
            for (int k = 0; k < LAT; k++) begin
                pipe_tag[k] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            last_grant  <= IDW'(NREQ - 1);
        end else begin
            issue_valid <= accept;
            if (accept) begin
                issue_tag  <= grant_idx;
                mul_a      <= req_a[grant_idx*32 +: 32];
                mul_b      <= req_b[grant_idx*32 +: 32];
                last_grant <= grant_idx;
            end

            // Tags only move alongside a valid bit so an idle pipe stays frozen.
            pipe_valid[0] <= issue_valid;
            if (issue_valid) begin
                pipe_tag[0] <= issue_tag;
            end
            for (int k = 1; k < LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_tag[k] <= pipe_tag[k-1];
                end
            end

            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= pipe_tag[LAT-1];
            fifo_data[wr_ptr] <= mul_result;
        end
    end

endmodule

// File: tb/tb_fp_mul_sched.sv
// Scoreboard bench for fp_mul_sched: a round-robin/credit model predicts grants and results,
// and a behavioural LAT-cycle multiplier stands in for the shared unit.
module tb_fp_mul_sched;

    localparam int NREQ  = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    localparam logic [31:0] TAB_A [2][4] = '{
        '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'hC0000000},
        '{32'h3FC00000, 32'h3F800000, 32'h40000000, 32'h40800000}};
    localparam logic [31:0] TAB_B [2][4] = '{
        '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h40400000},
        '{32'h3FC00000, 32'h3F800000, 32'h3F000000, 32'hC0000000}};
    // Hand-computed products: 1.5*2, 2*2, 3*0.5, -2*3 / 1.5*1.5, 1*1, 2*0.5, 4*-2
    localparam logic [31:0] TAB_P [2][4] = '{
        '{32'h40400000, 32'h40800000, 32'h3FC00000, 32'hC0C00000},
        '{32'h40100000, 32'h3F800000, 32'h3F800000, 32'hC1000000}};

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_result;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_ready;
    logic              busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   opset    = 0;
    int   mdl_last = NREQ - 1;
    int   mdl_count = 0;
    exp_t sb [$];
    logic [31:0] prod_pipe [LAT];

    fp_mul_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = TAB_A[opset][i];
            req_b[i*32 +: 32] = TAB_B[opset][i];
        end
    end

    // Exact single-precision multiply for normal operands with exactly representable products.
    function automatic logic [31:0] sp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) return {a[31] ^ b[31], 8'(e + 10'd1), p[46:24]};
        return {a[31] ^ b[31], e[7:0], p[45:23]};
    endfunction

    always @(posedge clk) begin
        prod_pipe[0] <= sp_mul(mul_a, mul_b);
        for (int k = 1; k < LAT; k++) prod_pipe[k] <= prod_pipe[k-1];
    end
    assign mul_result = prod_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rv, input logic rr, input int n);
        req_valid = rv;
        rsp_ready = rr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor and grant model: compares the FIFO head, predicts req_ready, pushes expectations.
    always @(negedge clk) begin
        logic       pop;
        logic       can;
        int         g;
        int         idx;
        logic [3:0] exp_ready;
        pop = rsp_valid && rsp_ready;
        if (reset) begin
            sb.delete();
            mdl_last  = NREQ - 1;
            mdl_count = 0;
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: got id %0d data %h, required no response (cycle %0d)",
                             rsp_id, rsp_data, cyc);
                end else begin
                    checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    checkOutput("rsp_data", rsp_data, sb[0].data);
                    if (pop) void'(sb.pop_front());
                end
            end
            can = (mdl_count - int'(pop)) < DEPTH;
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (mdl_last + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready = (g >= 0 && can) ? (4'b0001 << g) : 4'b0000;
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_ready != 4'b0000) begin
                sb.push_back('{id: 2'(g), data: TAB_P[opset][g]});
                mdl_last  = g;
                mdl_count = mdl_count + 1;
                acc_cyc   = cyc;
            end
            if (pop) mdl_count = mdl_count - 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;

        // Outputs while reset is held, even with every requester asking.
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'h0);
        checkOutput("reset_rsp_data", rsp_data, 32'h0);
        checkOutput("reset_mul_a", mul_a, 32'h0);
        checkOutput("reset_mul_b", mul_b, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 4'b0000;
        applyStimulus(4'b0000, 1'b1, 2);

        // Single request: latency LAT+2 from the accept cycle.
        applyStimulus(4'b0001, 1'b1, 1);
        req_valid = 4'b0000;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        checkOutput("latency_seen", 32'(found), 32'h1);
        checkOutput("latency_cycles", 32'(cyc - acc_cyc), 32'(LAT + 2));
        applyStimulus(4'b0000, 1'b1, 4);
        checkOutput("idle_busy", 32'(busy), 32'h0);

        // All requesters held: round-robin, one issue per cycle.
        applyStimulus(4'b1111, 1'b1, 12);
        applyStimulus(4'b0000, 1'b1, 10);

        // Second operand set, partial requester mask.
        opset = 1;
        applyStimulus(4'b1011, 1'b1, 7);
        applyStimulus(4'b0000, 1'b1, 10);

        // Consumer stalled: credit stops grants at DEPTH outstanding.
        opset = 0;
        applyStimulus(4'b0101, 1'b0, 14);
        checkOutput("stall_ready", 32'(req_ready), 32'h0);
        checkOutput("stall_busy", 32'(busy), 32'h1);
        applyStimulus(4'b0101, 1'b1, 1);
        applyStimulus(4'b0101, 1'b0, 8);
        checkOutput("stall_ready_again", 32'(req_ready), 32'h0);

        // Full FIFO: same-cycle pop frees the credit for requester 1.
        applyStimulus(4'b0010, 1'b1, 1);
        applyStimulus(4'b1111, 1'b0, 8);
        checkOutput("full_ready", 32'(req_ready), 32'h0);
        applyStimulus(4'b0000, 1'b1, 20);
        checkOutput("drain_busy", 32'(busy), 32'h0);
        checkOutput("drain_scoreboard", 32'(sb.size()), 32'h0);

        // Reset with three in flight and two queued.
        applyStimulus(4'b1111, 1'b0, 5);
        applyStimulus(4'b0000, 1'b0, 2);
        checkOutput("pre_reset_rsp_valid", 32'(rsp_valid), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("midreset_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("no_stale_rsp", 32'(rsp_valid), 32'h0);
        end
        checkOutput("post_reset_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;

        // First post-reset product comes only from a new accept.
        applyStimulus(4'b1000, 1'b1, 1);
        applyStimulus(4'b0000, 1'b1, 10);
        checkOutput("final_scoreboard", 32'(sb.size()), 32'h0);
        checkOutput("final_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
